// File: rtl/move_input_cond.sv
// move_input_cond: turns the four raw direction buttons into discrete move requests.
// Each button is synchronized and debounced. One direction is then picked by priority,
// and a request goes out once per press, plus auto-repeats while the button stays held.
// The consumer takes requests with a valid/ack handshake.
module move_input_cond #(
    parameter int unsigned c_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned c_REPEAT_DELAY   = 12500000,
    parameter int unsigned c_REPEAT_PERIOD  = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Btn_Up,
    input  logic       i_Btn_Dn,
    input  logic       i_Btn_Lt,
    input  logic       i_Btn_Rt,
    output logic       o_Move_Valid,
    output logic [1:0] o_Move_Dir,
    output logic       o_Move_Repeat,
    input  logic       i_Move_Ack,
    output logic [3:0] o_Btn_Held
);

    localparam int unsigned c_DB_W    = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam int unsigned c_TMR_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ?
                                        c_REPEAT_DELAY : c_REPEAT_PERIOD;
    localparam int unsigned c_TMR_W   = ($clog2(c_TMR_MAX) < 1) ? 1 : $clog2(c_TMR_MAX);

    // The level flips on the edge where the count would reach the limit.
    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(c_DEBOUNCE_LIMIT - 1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LOAD = c_TMR_W'(c_REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_LOAD = c_TMR_W'(c_REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDelay, StRepeat} state_e;

    // Bit order {Up, Dn, Lt, Rt} throughout.
    logic [3:0]        btn_raw;
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic [3:0]        held_q;
    logic [c_DB_W-1:0] cnt_q [4];

    logic              sel_any;
    logic [1:0]        sel_dir;

    state_e            state_q;
    logic              valid_q;
    logic [1:0]        dir_q;
    logic              rep_q;
    logic [c_TMR_W-1:0] timer_q;

    assign btn_raw = {i_Btn_Up, i_Btn_Dn, i_Btn_Lt, i_Btn_Rt};

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter debounce: accept a level change only after c_DEBOUNCE_LIMIT differing cycles.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            held_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == held_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == c_DB_LAST) begin
                    held_q[i] <= ~held_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Priority select Up > Dn > Lt > Rt on the debounced levels.
    always_comb begin
        sel_any = |held_q;
        sel_dir = 2'b11;
        if (held_q[3]) begin
            sel_dir = 2'b00;
        end else if (held_q[2]) begin
            sel_dir = 2'b01;
        end else if (held_q[1]) begin
            sel_dir = 2'b10;
        end
    end

    // Request FSM: issue once per press, hold until acked, then time the auto-repeat.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            dir_q   <= 2'b00;
            rep_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sel_any) begin
                        state_q <= StReq;
                        valid_q <= 1'b1;
                        dir_q   <= sel_dir;
                        rep_q   <= 1'b0;
                    end
                end
                StReq: begin
                    // Request stays up even if the button is released before the ack.
                    if (valid_q && i_Move_Ack) begin
                        valid_q <= 1'b0;
                        if (rep_q) begin
                            state_q <= StRepeat;
                            timer_q <= c_PERIOD_LOAD;
                        end else begin
                            state_q <= StDelay;
                            timer_q <= c_DELAY_LOAD;
                        end
                    end
                end
                StDelay, StRepeat: begin
                    if (!sel_any) begin
                        state_q <= StIdle;
                    end else if (sel_dir != dir_q) begin
                        // A different direction counts as a fresh press, no waiting.
                        state_q <= StReq;
                        valid_q <= 1'b1;
                        dir_q   <= sel_dir;
                        rep_q   <= 1'b0;
                    end else if (timer_q == '0) begin
                        state_q <= StReq;
                        valid_q <= 1'b1;
                        rep_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Move_Valid  = valid_q;
    assign o_Move_Dir    = dir_q;
    assign o_Move_Repeat = rep_q;
    assign o_Btn_Held    = held_q;

endmodule

// File: tb/tb_move_input_cond.sv
// tb_move_input_cond: directed scenarios plus randomized button/ack traffic, checked
// every cycle against a behavioural model of the button conditioner.
module tb_move_input_cond;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up  = 1'b0;
    logic       dn  = 1'b0;
    logic       lt  = 1'b0;
    logic       rt  = 1'b0;
    logic       ack = 1'b1;
    logic       valid;
    logic [1:0] dir;
    logic       rep;
    logic [3:0] held;

    move_input_cond #(
        .c_DEBOUNCE_LIMIT (DB),
        .c_REPEAT_DELAY   (RD),
        .c_REPEAT_PERIOD  (RP)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Btn_Up      (up),
        .i_Btn_Dn      (dn),
        .i_Btn_Lt      (lt),
        .i_Btn_Rt      (rt),
        .o_Move_Valid  (valid),
        .o_Move_Dir    (dir),
        .o_Move_Repeat (rep),
        .i_Move_Ack    (ack),
        .o_Btn_Held    (held)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Held level flips once the last DB synchronized samples (raw pin delayed two edges)
    // all disagree with it. Requests: one per press, then a repeat at an absolute
    // deadline measured from the accepting edge.
    bit [63:0] m_hist [4];
    logic [3:0] m_held;
    bit        m_valid;
    bit [1:0]  m_dir;
    bit        m_rep;
    int        m_mode;      // 0 no request, 1 request outstanding, 2 waiting for repeat
    longint    m_cyc;
    longint    m_deadline;
    bit        m_all_diff;
    logic [3:0] pins;

    assign pins = {up, dn, lt, rt};

    function automatic bit [1:0] prio(input logic [3:0] h);
        if (h[3]) return 2'd0;
        if (h[2]) return 2'd1;
        if (h[1]) return 2'd2;
        return 2'd3;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_hist[i] = '0;
            m_held  = '0;
            m_valid = 0;
            m_dir   = 0;
            m_rep   = 0;
            m_mode  = 0;
            m_cyc   = 0;
            m_deadline = 0;
        end else begin
            m_cyc++;
            if (m_mode == 0) begin
                if (m_held != 0) begin
                    m_valid = 1; m_dir = prio(m_held); m_rep = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (m_valid && ack) begin
                    m_valid = 0; m_mode = 2;
                    m_deadline = m_cyc + (m_rep ? RP : RD);
                end
            end else begin
                if (m_held == 0) begin
                    m_mode = 0;
                end else if (prio(m_held) != m_dir) begin
                    m_valid = 1; m_dir = prio(m_held); m_rep = 0; m_mode = 1;
                end else if (m_cyc == m_deadline) begin
                    m_valid = 1; m_rep = 1; m_mode = 1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_all_diff = 1;
                for (int j = 1; j <= DB; j++) begin
                    if (m_hist[i][j] == m_held[i]) m_all_diff = 0;
                end
                if (m_all_diff) m_held[i] = ~m_held[i];
                m_hist[i] = {m_hist[i][62:0], pins[i]};
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("held", int'(held), int'(m_held));
            chk("valid", int'(valid), int'(m_valid));
            if (m_valid) begin
                chk("dir", int'(dir), int'(m_dir));
                chk("repeat", int'(rep), int'(m_rep));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; up = 0; dn = 0; lt = 0; rt = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_repeat", int'(rep), 0);
        chk("rst_dir", int'(dir), 0);
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    int nv;
    int first;
    int bad;
    bit found;

    initial begin
        // 1/6: clean Up press, ack tied high; ack coincides with the first Valid.
        ack = 1;
        do_reset();
        up = 1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            if (k == 5) chk("t1_held_k5", int'(held), 0);
            if (k == 6) begin
                chk("t1_held_k6", int'(held), 8);
                chk("t1_model_held_k6", int'(m_held), 8);
                chk("t1_valid_k6", int'(valid), 0);
            end
            if (k == 7) begin
                chk("t1_valid_k7", int'(valid), 1);
                chk("t1_dir_k7", int'(dir), 0);
                chk("t1_rep_k7", int'(rep), 0);
                chk("t1_model_valid_k7", int'(m_valid), 1);
            end
            if (k == 8) chk("t1_valid_k8", int'(valid), 0);
            if (k == 27) chk("t1_valid_k27", int'(valid), 0);
            if (k == 28) begin
                chk("t1_valid_k28", int'(valid), 1);
                chk("t1_rep_k28", int'(rep), 1);
                chk("t1_model_valid_k28", int'(m_valid), 1);
            end
            if (k == 29) chk("t1_valid_k29", int'(valid), 0);
            if (k == 36) chk("t1_valid_k36", int'(valid), 0);
            if (k == 37) begin
                chk("t1_valid_k37", int'(valid), 1);
                chk("t1_rep_k37", int'(rep), 1);
            end
        end

        // 2: bouncing Lt, then settle high.
        do_reset();
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            lt = ((k / 2) % 2 == 0);
            @(negedge clk);
            if (valid) nv++;
        end
        lt = 1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (valid) begin
                nv++;
                if (first == 0) begin
                    first = k;
                    chk("t2_dir", int'(dir), 2);
                end
            end
        end
        chk("t2_first_valid", first, 7);
        chk("t2_valid_count", nv, 1);

        // 3: ack held low, press Rt and release; request persists until one ack pulse.
        do_reset();
        ack = 0;
        rt = 1;
        bad = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 51) rt = 0;
            @(negedge clk);
            if (k >= 7 && (!valid || dir != 2'd3)) bad++;
        end
        chk("t3_hold_valid", bad, 0);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("t3_after_ack", int'(valid), 0);
        nv = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("t3_no_repeat", nv, 0);
        ack = 1;

        // 4: Up held, Dn added at 15, Up released at 40 -> fresh Dn request.
        do_reset();
        up = 1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 15) dn = 1;
            @(negedge clk);
            if (valid && dir != 2'd0) bad++;
        end
        chk("t4_dir_up_while_held", bad, 0);
        up = 0;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!found && valid && dir == 2'd1) begin
                found = 1;
                chk("t4_dn_fresh", int'(rep), 0);
            end
        end
        chk("t4_dn_found", int'(found), 1);

        // 5: async reset in the middle of an outstanding request.
        do_reset();
        ack = 0;
        up = 1;
        repeat (10) @(negedge clk);
        chk("t5_valid_before", int'(valid), 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t5_async_valid", int'(valid), 0);
        chk("t5_async_held", int'(held), 0);
        @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                chk("t5_held_k6", int'(held), 8);
                chk("t5_valid_k6", int'(valid), 0);
            end
            if (k == 7) begin
                chk("t5_valid_k7", int'(valid), 1);
                chk("t5_dir_k7", int'(dir), 0);
                chk("t5_rep_k7", int'(rep), 0);
            end
        end
        ack = 1;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) up = ~up;
            if ($urandom_range(0, 29) == 0) dn = ~dn;
            if ($urandom_range(0, 29) == 0) lt = ~lt;
            if ($urandom_range(0, 29) == 0) rt = ~rt;
            ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
        end
        up = 0; dn = 0; lt = 0; rt = 0; ack = 1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
